decode_redirect_ctrl: RTL and testbench

Sequencer between the dual-issue decode stage and the fetch unit. It turns the decoder's restart indications (mispredicted-taken on a non-branch, invalid instruction) into a single fetch redirect, then stalls decode while stale fetch-pipe entries drain. It reports illegal instructions as a precise exception once the backend is empty. It also holds the return-address stack that is fed by decoded calls and returns.

---
 rtl/decode_redirect_ctrl_pkg.sv | 19 +
 rtl/decode_redirect_ctrl_ras_stack.sv | 60 ++++++
 rtl/decode_redirect_ctrl.sv | 141 ++++++++++++++
 tb/tb_decode_redirect_ctrl.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/decode_redirect_ctrl_pkg.sv
// Shared types for the decode redirect sequencer.
// Holds the FSM state enum and the RAS pointer-width helper.
package decode_redirect_ctrl_pkg;

   typedef enum logic [2:0] {
      ST_RUN,
      ST_REDIRECT,
      ST_DRAIN,
      ST_ILL_WAIT,
      ST_EXC,
      ST_HALT
   } redirect_state_e;

   // Pointer width for a power-of-two stack; at least one bit.
   function automatic int ras_ptr_w(input int depth);
      return (depth <= 2) ? 1 : $clog2(depth);
   endfunction

endpackage

// File: rtl/decode_redirect_ctrl_ras_stack.sv
// Return-address stack: push, pop, replace-top, top-of-stack read.
// Ports: clk, rst, push, pop, data (pushed addr), top, empty.
module ras_stack
   import decode_redirect_ctrl_pkg::*;
#(
   parameter int DEPTH = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        push,
   input  logic        pop,
   input  logic [31:0] data,
   output logic [31:0] top,
   output logic        empty
);

   localparam int PW = ras_ptr_w(DEPTH);
   localparam int CW = PW + 1;

   logic [31:0]   mem [DEPTH];
   logic [PW-1:0] ptr;
   logic [PW-1:0] ptr_m1;
   logic [CW-1:0] cnt;
   logic          full;
   logic          none;

   assign ptr_m1 = ptr - PW'(1);
   assign full   = (cnt == CW'(DEPTH));
   assign none   = (cnt == '0);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ptr <= '0;
         cnt <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else begin
         if (push && (!pop || none)) begin
            // Wrapping pointer: a push when full
            // overwrites the oldest entry.
            mem[ptr] <= data;
            ptr      <= ptr + PW'(1);
            if (!full) begin
               cnt <= cnt + CW'(1);
            end
         end else if (push && pop) begin
            // Return then call: replace the top.
            mem[ptr_m1] <= data;
         end else if (pop && !none) begin
            ptr <= ptr_m1;
            cnt <= cnt - CW'(1);
         end
      end
   end

   assign top   = none ? '0 : mem[ptr_m1];
   assign empty = none;

endmodule

// File: rtl/decode_redirect_ctrl.sv
// Decode-to-fetch restart sequencer: redirect, drain, illegal-instr
// exception, plus the call/return RAS. Ports: dec_* decoder events,
// flush_i/rob_empty_i backend, fe_redirect_* fetch handshake,
// bp_invalidate_o, exc_*, ras_* predictor feed, dec_stall_o.
module decode_redirect_ctrl
   import decode_redirect_ctrl_pkg::*;
#(
   parameter int DRAIN_CYCLES = 2,
   parameter int RAS_DEPTH    = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        dec_valid_transaction,
   input  logic        dec_invalid_prediction,
   input  logic        dec_invalid_instruction,
   input  logic [31:0] dec_old_pc,
   input  logic        dec_is_call,
   input  logic        dec_is_return,
   input  logic        flush_i,
   input  logic        rob_empty_i,
   output logic        dec_stall_o,
   output logic        fe_redirect_valid_o,
   output logic [31:0] fe_redirect_pc_o,
   input  logic        fe_redirect_ready_i,
   output logic        bp_invalidate_o,
   output logic        exc_valid_o,
   output logic [31:0] exc_pc_o,
   output logic [31:0] ras_target_o,
   output logic        ras_empty_o
);

   localparam int CW =
      (DRAIN_CYCLES > 0) ? $clog2(DRAIN_CYCLES + 1) : 1;

   redirect_state_e state;
   logic [CW-1:0]   cnt;
   logic            bp_flag;
   logic [31:0]     redir_pc;
   logic [31:0]     exc_pc;

   logic in_run;
   logic event_any;
   logic accept;
   logic ras_en;

   // Slot validity is already folded into the event and
   // call/return flags by the decoder.
   logic unused_valid;
   assign unused_valid = dec_valid_transaction;

   assign in_run    = (state == ST_RUN) && !flush_i;
   assign event_any = dec_invalid_prediction
                    | dec_invalid_instruction;
   assign accept    = (state == ST_REDIRECT) && !flush_i
                    && fe_redirect_ready_i;
   assign ras_en    = in_run && !event_any;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= ST_RUN;
         cnt      <= '0;
         bp_flag  <= 1'b0;
         redir_pc <= '0;
         exc_pc   <= '0;
      end else if (flush_i) begin
         state   <= ST_RUN;
         cnt     <= '0;
         bp_flag <= 1'b0;
      end else begin
         case (state)
            ST_RUN: begin
               if (dec_invalid_prediction) begin
                  redir_pc <= dec_old_pc;
                  bp_flag  <= 1'b1;
                  state    <= ST_REDIRECT;
               end else if (dec_invalid_instruction) begin
                  exc_pc <= dec_old_pc;
                  state  <= ST_ILL_WAIT;
               end
            end
            ST_REDIRECT: begin
               if (fe_redirect_ready_i) begin
                  bp_flag <= 1'b0;
                  if (DRAIN_CYCLES == 0) begin
                     state <= ST_RUN;
                  end else begin
                     cnt   <= CW'(DRAIN_CYCLES);
                     state <= ST_DRAIN;
                  end
               end
            end
            ST_DRAIN: begin
               if (cnt <= CW'(1)) begin
                  cnt   <= '0;
                  state <= ST_RUN;
               end else begin
                  cnt <= cnt - CW'(1);
               end
            end
            ST_ILL_WAIT: begin
               if (rob_empty_i) begin
                  state <= ST_EXC;
               end
            end
            ST_EXC: begin
               state <= ST_HALT;
            end
            ST_HALT: begin
               state <= ST_HALT;
            end
            default: begin
               state <= ST_RUN;
            end
         endcase
      end
   end

   // Stall in the event cycle itself so the offending
   // bundle's successors never enter decode.
   assign dec_stall_o = !in_run || event_any;

   assign fe_redirect_valid_o = (state == ST_REDIRECT)
                              && !flush_i;
   assign fe_redirect_pc_o    = redir_pc;
   assign bp_invalidate_o     = accept && bp_flag;
   assign exc_valid_o         = (state == ST_EXC) && !flush_i;
   assign exc_pc_o            = exc_pc;

   ras_stack #(
      .DEPTH (RAS_DEPTH)
   ) u_ras (
      .clk   (clk),
      .rst   (rst),
      .push  (ras_en && dec_is_call),
      .pop   (ras_en && dec_is_return),
      .data  (dec_old_pc),
      .top   (ras_target_o),
      .empty (ras_empty_o)
   );

endmodule

// File: tb/tb_decode_redirect_ctrl.sv
// Bench for decode_redirect_ctrl: cycle vector table with a
// queue scoreboard, plus an async-reset sequence.
module tb_decode_redirect_ctrl;

   typedef struct {
      logic        stall;
      logic        rv;
      logic [31:0] rpc;
      logic        bpi;
      logic        ev;
      logic [31:0] epc;
      logic [31:0] top;
      logic        emp;
   } exp_t;

   typedef struct {
      logic        ip;
      logic        ii;
      logic [31:0] pc;
      logic        call;
      logic        ret;
      logic        fl;
      logic        rob;
      logic        rdy;
      exp_t        e;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        dvt = 1'b0;
   logic        ip = 1'b0;
   logic        ii = 1'b0;
   logic [31:0] pc = '0;
   logic        call = 1'b0;
   logic        ret = 1'b0;
   logic        fl = 1'b0;
   logic        rob = 1'b1;
   logic        rdy = 1'b0;
   logic        stall;
   logic        rv;
   logic [31:0] rpc;
   logic        bpi;
   logic        ev;
   logic [31:0] epc;
   logic [31:0] top;
   logic        emp;

   int   n_tests = 0;
   int   n_fail  = 0;
   vec_t tv[$];
   exp_t expq[$];

   always #5 clk = ~clk;

   decode_redirect_ctrl #(
      .DRAIN_CYCLES (2),
      .RAS_DEPTH    (8)
   ) dut (
      .clk                     (clk),
      .rst                     (rst),
      .dec_valid_transaction   (dvt),
      .dec_invalid_prediction  (ip),
      .dec_invalid_instruction (ii),
      .dec_old_pc              (pc),
      .dec_is_call             (call),
      .dec_is_return           (ret),
      .flush_i                 (fl),
      .rob_empty_i             (rob),
      .dec_stall_o             (stall),
      .fe_redirect_valid_o     (rv),
      .fe_redirect_pc_o        (rpc),
      .fe_redirect_ready_i     (rdy),
      .bp_invalidate_o         (bpi),
      .exc_valid_o             (ev),
      .exc_pc_o                (epc),
      .ras_target_o            (top),
      .ras_empty_o             (emp)
   );

   function automatic vec_t v(
      input logic ip_, ii_, input logic [31:0] pc_,
      input logic call_, ret_, fl_, rob_, rdy_,
      input logic st_, rv_, input logic [31:0] rpc_,
      input logic bpi_, ev_, input logic [31:0] epc_,
      input logic [31:0] top_, input logic emp_);
      vec_t r;
      r.ip = ip_;  r.ii = ii_;  r.pc = pc_;
      r.call = call_;  r.ret = ret_;  r.fl = fl_;
      r.rob = rob_;  r.rdy = rdy_;
      r.e.stall = st_;  r.e.rv = rv_;  r.e.rpc = rpc_;
      r.e.bpi = bpi_;  r.e.ev = ev_;  r.e.epc = epc_;
      r.e.top = top_;  r.e.emp = emp_;
      return r;
   endfunction

   function automatic exp_t ex(
      input logic st_, rv_, input logic [31:0] rpc_,
      input logic bpi_, ev_, input logic [31:0] epc_,
      input logic [31:0] top_, input logic emp_);
      exp_t r;
      r.stall = st_;  r.rv = rv_;  r.rpc = rpc_;
      r.bpi = bpi_;  r.ev = ev_;  r.epc = epc_;
      r.top = top_;  r.emp = emp_;
      return r;
   endfunction

   task automatic chk(input string n, input int idx,
                      input logic [31:0] act,
                      input logic [31:0] want);
      n_tests++;
      if (act !== want) begin
         n_fail++;
         $display("FAIL v%0d %s: got %h want %h",
                  idx, n, act, want);
      end
   endtask

   task automatic compare(input int idx);
      exp_t e;
      if (expq.size() == 0) begin
         n_tests++;
         n_fail++;
         $display("FAIL v%0d scoreboard: got empty want entry",
                  idx);
         return;
      end
      e = expq.pop_front();
      chk("stall", idx, {31'd0, stall}, {31'd0, e.stall});
      chk("redir_valid", idx, {31'd0, rv}, {31'd0, e.rv});
      chk("redir_pc", idx, rpc, e.rpc);
      chk("bp_inv", idx, {31'd0, bpi}, {31'd0, e.bpi});
      chk("exc_valid", idx, {31'd0, ev}, {31'd0, e.ev});
      chk("exc_pc", idx, epc, e.epc);
      chk("ras_top", idx, top, e.top);
      chk("ras_empty", idx, {31'd0, emp}, {31'd0, e.emp});
   endtask

   task automatic drive(input vec_t t);
      ip = t.ip;  ii = t.ii;  pc = t.pc;
      call = t.call;  ret = t.ret;  fl = t.fl;
      rob = t.rob;  rdy = t.rdy;
      dvt = t.ip | t.ii | t.call | t.ret;
   endtask

   initial begin
      // redirect, ready delayed 3 cycles
      tv.push_back(v(1,0,'h100,0,0,0,1,0, 1,0,0,0,0,0,0,1));
      for (int i = 0; i < 3; i++)
         tv.push_back(v(0,0,0,0,0,0,1,0, 1,1,'h100,0,0,0,0,1));
      tv.push_back(v(0,0,0,0,0,0,1,1, 1,1,'h100,1,0,0,0,1));
      tv.push_back(v(0,0,0,0,0,0,1,0, 1,0,'h100,0,0,0,0,1));
      tv.push_back(v(0,0,0,0,0,0,1,0, 1,0,'h100,0,0,0,0,1));
      tv.push_back(v(0,0,0,0,0,0,1,0, 0,0,'h100,0,0,0,0,1));
      // both events: redirect wins; event in DRAIN ignored
      tv.push_back(v(1,1,'h300,0,0,0,1,0, 1,0,'h100,0,0,0,0,1));
      tv.push_back(v(0,0,0,0,0,0,1,1, 1,1,'h300,1,0,0,0,1));
      tv.push_back(v(1,0,'h333,0,0,0,1,0, 1,0,'h300,0,0,0,0,1));
      tv.push_back(v(0,0,0,0,0,0,1,0, 1,0,'h300,0,0,0,0,1));
      tv.push_back(v(0,0,0,0,0,0,1,0, 0,0,'h300,0,0,0,0,1));
      // illegal instruction, backend busy 5 cycles
      tv.push_back(v(0,1,'h2004,0,0,0,0,0, 1,0,'h300,0,0,0,0,1));
      for (int i = 0; i < 5; i++)
         tv.push_back(v(0,0,0,0,0,0,0,0,
                        1,0,'h300,0,0,'h2004,0,1));
      tv.push_back(v(0,0,0,0,0,0,1,0, 1,0,'h300,0,0,'h2004,0,1));
      tv.push_back(v(0,0,0,0,0,0,1,0, 1,0,'h300,0,1,'h2004,0,1));
      tv.push_back(v(0,0,0,0,0,0,1,0, 1,0,'h300,0,0,'h2004,0,1));
      tv.push_back(v(1,0,'h444,0,0,0,1,0,
                     1,0,'h300,0,0,'h2004,0,1));
      tv.push_back(v(0,0,0,0,0,1,1,0, 1,0,'h300,0,0,'h2004,0,1));
      tv.push_back(v(0,0,0,0,0,0,1,0, 0,0,'h300,0,0,'h2004,0,1));
      // 9 calls overflow the 8-deep stack
      for (int k = 1; k <= 9; k++)
         tv.push_back(v(0,0,32'(k*16),1,0,0,1,0,
                        0,0,'h300,0,0,'h2004,
                        (k == 1) ? 32'd0 : 32'((k-1)*16),
                        (k == 1)));
      for (int j = 0; j < 8; j++)
         tv.push_back(v(0,0,0,0,1,0,1,0,
                        0,0,'h300,0,0,'h2004,32'((9-j)*16),0));
      tv.push_back(v(0,0,0,0,1,0,1,0, 0,0,'h300,0,0,'h2004,0,1));
      // call+return replaces the top
      tv.push_back(v(0,0,'h30,1,0,0,1,0, 0,0,'h300,0,0,'h2004,0,1));
      tv.push_back(v(0,0,'h40,1,0,0,1,0,
                     0,0,'h300,0,0,'h2004,'h30,0));
      tv.push_back(v(0,0,'h500,1,1,0,1,0,
                     0,0,'h300,0,0,'h2004,'h40,0));
      tv.push_back(v(0,0,0,0,1,0,1,0, 0,0,'h300,0,0,'h2004,'h500,0));
      tv.push_back(v(0,0,0,0,1,0,1,0, 0,0,'h300,0,0,'h2004,'h30,0));
      tv.push_back(v(0,0,0,0,0,0,1,0, 0,0,'h300,0,0,'h2004,0,1));
      tv.push_back(v(0,0,'h600,1,1,0,1,0,
                     0,0,'h300,0,0,'h2004,0,1));
      tv.push_back(v(0,0,0,0,0,0,1,0, 0,0,'h300,0,0,'h2004,'h600,0));
      // flush mid-REDIRECT, call ignored in flush cycle
      tv.push_back(v(1,0,'h700,0,0,0,1,0,
                     1,0,'h300,0,0,'h2004,'h600,0));
      tv.push_back(v(0,0,0,0,0,0,1,0, 1,1,'h700,0,0,'h2004,'h600,0));
      tv.push_back(v(0,0,'h999,1,0,1,1,1,
                     1,0,'h700,0,0,'h2004,'h600,0));
      tv.push_back(v(0,0,0,0,0,0,1,0, 0,0,'h700,0,0,'h2004,'h600,0));
      // flush mid-DRAIN, return ignored in flush cycle
      tv.push_back(v(1,0,'h800,0,0,0,1,0,
                     1,0,'h700,0,0,'h2004,'h600,0));
      tv.push_back(v(0,0,0,0,0,0,1,1, 1,1,'h800,1,0,'h2004,'h600,0));
      tv.push_back(v(0,0,0,0,1,1,1,0, 1,0,'h800,0,0,'h2004,'h600,0));
      tv.push_back(v(0,0,0,0,0,0,1,0, 0,0,'h800,0,0,'h2004,'h600,0));
      // enter DRAIN for the async reset check
      tv.push_back(v(1,0,'h900,0,0,0,1,0,
                     1,0,'h800,0,0,'h2004,'h600,0));
      tv.push_back(v(0,0,0,0,0,0,1,1, 1,1,'h900,1,0,'h2004,'h600,0));
      tv.push_back(v(0,0,0,0,0,0,1,0, 1,0,'h900,0,0,'h2004,'h600,0));

      // reset state
      repeat (2) @(posedge clk);
      @(negedge clk);
      expq.push_back(ex(0,0,0,0,0,0,0,1));
      compare(-1);
      #2 rst = 1'b0;

      for (int i = 0; i < tv.size(); i++) begin
         @(posedge clk);
         #1;
         drive(tv[i]);
         expq.push_back(tv[i].e);
         @(negedge clk);
         compare(i);
      end

      // async reset mid-DRAIN, no clock edge
      #2 rst = 1'b1;
      #1;
      expq.push_back(ex(0,0,0,0,0,0,0,1));
      compare(1000);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      expq.push_back(ex(0,0,0,0,0,0,0,1));
      @(negedge clk);
      compare(1001);

      $display("[TB] %0d tests run, %0d failed",
               n_tests, n_fail);
      $finish;
   end

endmodule
